uart_decoder: RTL
=================

// Module: uart_decoder
// PURPOSE
//  Receive-side counterpart of the blackjack UART link. Pops bytes from the UART RX FIFO,
//  reassembles the 10-byte status frame (slot 0 = flags, slots 1..9 = dealer cards) into a
//  shadow buffer, and commits it atomically to the remote-table outputs with a 1-cycle strobe.
//  Byte format: [7:4] payload, [3:0] slot index; slot 0 payload = {2'b00, deal, dealer_finished}.
// PARAMETERS
//  NUM_CARDS       9        dealer card slots per frame (slots 1..NUM_CARDS)
//  TIMEOUT_CYCLES  100_000  max idle clocks between frame bytes (used only with UART_DEC_TIMEOUT_EN)
// PORTS
//  clk                   in   1     system clock; the only clock
//  rst_n                 in   1     reset, asynchronous, active-low
//  rx_empty              in   1     RX FIFO empty; r_data valid (first-word-fall-through) when 0
//  r_data                in   8     RX FIFO head byte
//  rd_uart               out  1     RX FIFO pop, registered 1-cycle pulse
//  remote_deal           out  1     committed slot-0 bit 5
//  remote_dealer_finished out 1     committed slot-0 bit 4
//  remote_card_values    out  4x9   committed dealer card values [0:NUM_CARDS-1]
//  frame_valid           out  1     1-cycle pulse on commit
//  frame_err             out  1     1-cycle pulse on slot sequence error / timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, card array 0, shadow 0, FSM=HUNT, expected slot=0.
//  Fetch: when rx_empty=0 and rd_uart=0, capture r_data into byte_q and set rd_uart=1 next
//   cycle; never capture while rd_uart=1 -> at most one byte per 2 clocks, no double pop.
//   Captured byte is processed the cycle after capture (same cycle rd_uart is high).
//  FSM states:
//   HUNT    : discard bytes with slot!=0; slot 0 -> latch flags to shadow, exp=1, -> COLLECT.
//   COLLECT : slot==exp -> shadow_card[exp-1]=payload; exp==NUM_CARDS -> COMMIT else exp+1.
//             slot==0   -> frame_err pulse, restart: latch flags, exp=1, stay COLLECT.
//             other     -> frame_err pulse, -> HUNT (slot>NUM_CARDS counts as other).
//   COMMIT  : one cycle; copy shadow to remote_* outputs, frame_valid=1, -> HUNT.
//  Outputs change only in COMMIT; partial/aborted frames never reach remote_* outputs.
//  frame_valid and frame_err are never both 1; both registered.
//  Slot-0 payload bits [7:6] ignored. Fetch continues in COMMIT; byte fetched there is
//   processed in HUNT.
//  rx_empty rising mid-frame: FSM waits in COLLECT indefinitely (unless timeout enabled).
// CONFIGURATION
//  UART_DEC_TIMEOUT_EN defined: 32-bit idle counter runs in COLLECT, cleared on each processed
//   byte; reaching TIMEOUT_CYCLES -> frame_err pulse, shadow discarded, -> HUNT.
//  Not defined: no counter, no timeout; TIMEOUT_CYCLES unused.
// STRUCTURE
//  uart_pkg: SLOT_FLAGS=4'd0, SLOT_W=4, CARD_W=4, card_t, dec_state_t {HUNT,COLLECT,COMMIT},
//   bit positions DEAL_BIT=5, DFIN_BIT=4. Shared with uart_encoder.
//  Single module; byte fetch kept inline (no sub-module warranted at this size).
// TESTING
//  1 Reset mid-frame: assert rst_n=0 after 4 bytes -> all outputs 0 same cycle, FSM HUNT.
//  2 Clean frame 0x20,0x51,0xA2,0x33,0x04..0x09 -> one frame_valid, deal=1, dfin=0,
//    cards[0]=5,[1]=A,[2]=3,[3..8]=0; rd_uart pulses exactly 10 times, never 2 consecutive.
//  3 Leading junk 0x13,0x25 then clean frame -> junk dropped, no frame_err, one frame_valid.
//  4 Skip: 0x10,0x71,0x83(slot 3, exp 2) -> frame_err once, outputs unchanged, then full
//    frame with flags 0x10 -> dealer_finished=1, frame_valid once.
//  5 Restart: 0x00,0x41,0x20,0x91..0x99(payload 9) -> frame_err once, committed deal=1, all cards=9.
//  6 UART_DEC_TIMEOUT_EN, TIMEOUT_CYCLES=50: 0x00,0x11 then rx_empty=1 for 60 cycles ->
//    frame_err at cycle 50, outputs unchanged; without macro -> no pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the blackjack UART link (used by uart_encoder and
// uart_decoder).
// Byte format on the wire: [7:4] payload, [3:0] slot index.
// Slot 0 carries the flags: payload = {2'b00, deal, dealer_finished}.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned SLOT_W = 4;
    localparam int unsigned CARD_W = 4;

    localparam logic [SLOT_W-1:0] SLOT_FLAGS = 4'd0;

    // Bit positions of the flags within a slot-0 byte
    localparam int unsigned DEAL_BIT = 5;
    localparam int unsigned DFIN_BIT = 4;

    typedef logic [CARD_W-1:0] card_t;

    typedef enum logic [1:0] {
        HUNT,
        COLLECT,
        COMMIT
    } dec_state_t;

endpackage

// File: rtl/uart_decoder.sv
// -----------------------------------------------------------------------------
// uart_decoder
// Receive side of the blackjack UART link. Pops bytes from the RX FIFO,
// reassembles the status frame (slot 0 = flags, slots 1..NUM_CARDS = dealer
// cards) into a shadow buffer and commits it atomically to the remote_*
// outputs together with a one-cycle frame_valid strobe. Sequence errors
// produce a one-cycle frame_err strobe and never disturb the outputs.
//
// Optional feature: define UART_DEC_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES idle clocks in COLLECT (frame_err pulse, back to HUNT).
//
// Ports
//   clk                     system clock
//   rst_n                   asynchronous active-low reset
//   rx_empty                RX FIFO empty (r_data valid when 0, FWFT)
//   r_data[7:0]             RX FIFO head byte
//   rd_uart                 RX FIFO pop, registered 1-cycle pulse
//   remote_deal             committed slot-0 bit 5
//   remote_dealer_finished  committed slot-0 bit 4
//   remote_card_values      committed dealer cards [0:NUM_CARDS-1]
//   frame_valid             1-cycle pulse on commit
//   frame_err               1-cycle pulse on sequence error / timeout
// -----------------------------------------------------------------------------
module uart_decoder
    import uart_pkg::*;
#(
    parameter int unsigned NUM_CARDS      = 9,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_empty,
    input  logic [7:0]              r_data,
    output logic                    rd_uart,
    output logic                    remote_deal,
    output logic                    remote_dealer_finished,
    output card_t [0:NUM_CARDS-1]   remote_card_values,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CARDS);

    logic [7:0]             byte_q;
    dec_state_t             state;
    logic [SLOT_W-1:0]      exp_slot;
    logic                   shadow_deal;
    logic                   shadow_dfin;
    card_t [0:NUM_CARDS-1]  shadow_cards;

    logic [SLOT_W-1:0]      slot;
    card_t                  payload;
    logic [SLOT_W-1:0]      card_idx;

    assign slot     = byte_q[SLOT_W-1:0];
    assign payload  = byte_q[7:4];
    assign card_idx = exp_slot - 1'b1;

    // Byte fetch: capture the head and pop it on the following cycle. No
    // capture while rd_uart is high, so the same head is never taken twice.
    // The captured byte is processed in the cycle rd_uart is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q  <= '0;
            rd_uart <= 1'b0;
        end else if (!rx_empty && !rd_uart) begin
            byte_q  <= r_data;
            rd_uart <= 1'b1;
        end else begin
            rd_uart <= 1'b0;
        end
    end

`ifdef UART_DEC_TIMEOUT_EN
    logic [31:0] idle_cnt;
`else
    // Timeout disabled: the parameter is kept only for interface compatibility.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= HUNT;
            exp_slot               <= '0;
            shadow_deal            <= 1'b0;
            shadow_dfin            <= 1'b0;
            shadow_cards           <= '0;
            remote_deal            <= 1'b0;
            remote_dealer_finished <= 1'b0;
            remote_card_values     <= '0;
            frame_valid            <= 1'b0;
            frame_err              <= 1'b0;
`ifdef UART_DEC_TIMEOUT_EN
            idle_cnt               <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
`ifdef UART_DEC_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
            case (state)
                HUNT: begin
                    if (rd_uart && slot == SLOT_FLAGS) begin
                        shadow_deal <= byte_q[DEAL_BIT];
                        shadow_dfin <= byte_q[DFIN_BIT];
                        exp_slot    <= 4'd1;
                        state       <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (rd_uart) begin
                        if (slot == exp_slot) begin
                            shadow_cards[card_idx] <= payload;
                            if (exp_slot == LAST_SLOT) begin
                                state <= COMMIT;
                            end else begin
                                exp_slot <= exp_slot + 1'b1;
                            end
                        end else if (slot == SLOT_FLAGS) begin
                            // A fresh flags byte restarts the frame in place
                            frame_err   <= 1'b1;
                            shadow_deal <= byte_q[DEAL_BIT];
                            shadow_dfin <= byte_q[DFIN_BIT];
                            exp_slot    <= 4'd1;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= HUNT;
                        end
                    end
`ifdef UART_DEC_TIMEOUT_EN
                    else if (idle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
`endif
                end

                COMMIT: begin
                    remote_deal            <= shadow_deal;
                    remote_dealer_finished <= shadow_dfin;
                    remote_card_values     <= shadow_cards;
                    frame_valid            <= 1'b1;
                    state                  <= HUNT;
                end

                default: state <= HUNT;
            endcase
        end
    end

endmodule
